// File: rtl/iq_sample_fifo.sv
// iq_sample_fifo: first-word-fall-through FIFO for complex (I/Q) sample pairs.
//
// Sits between a sample producer and a downstream datapath that pulls samples.
// The head entry is always visible on OutI/OutQ. When the FIFO is empty these
// outputs are forced to zero.
//
// Parameters:
//   W        width of each of I and Q
//   DEPTH    number of entries (power of two, >= 2)
//   AF_LEVEL occupancy at which AlmostFull asserts (1..DEPTH)
//
// Ports:
//   Clk, ResetN          clock, asynchronous active-low reset
//   PushIn, SampI, SampQ write request and sample pair
//   PullOut              read request, pops the head entry
//   OutI, OutQ           head entry (zero when Empty)
//   Empty, Full          occupancy == 0 / occupancy == DEPTH
//   AlmostFull           occupancy >= AF_LEVEL
//   Count                occupancy, 0..DEPTH
//   ClrErr               clears sticky error state
//   Overflow, Underflow  sticky error flags
//   DropCnt              saturating count of dropped pushes
//
// Optional feature macro: IQ_FIFO_ERR_EN.
//   Defined:   error tracking is live.
//   Undefined: the error outputs are tied to 0, ClrErr is ignored, and no
//              error-tracking flops are built.
module iq_sample_fifo #(
  parameter int unsigned W        = 24,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic                     PushIn,
  input  logic [W-1:0]             SampI,
  input  logic [W-1:0]             SampQ,
  input  logic                     PullOut,
  output logic [W-1:0]             OutI,
  output logic [W-1:0]             OutQ,
  output logic                     Empty,
  output logic                     Full,
  output logic                     AlmostFull,
  output logic [$clog2(DEPTH):0]   Count,
  input  logic                     ClrErr,
  output logic                     Overflow,
  output logic                     Underflow,
  output logic [7:0]               DropCnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 2 * W;

  // Each entry stores {Q, I}
  logic [DW-1:0] mem [DEPTH];

  // The extra MSB on each pointer distinguishes full from empty
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          push_ok;
  logic          pull_ok;
  logic [DW-1:0] head;

  // Status flags are derived from the registered pointers
  assign Empty      = (wr_ptr == rd_ptr);
  assign Full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                      (wr_ptr[AW] != rd_ptr[AW]);
  assign Count      = wr_ptr - rd_ptr;
  assign AlmostFull = (Count >= PW'(AF_LEVEL));

  // A pull frees a slot in the same cycle, so a push into a full FIFO is
  // accepted only when a pull accompanies it. A pull into an empty FIFO is
  // ignored, and any push in that cycle is still written.
  assign pull_ok = PullOut && !Empty;
  assign push_ok = PushIn && (!Full || PullOut);

  // Pointer registers
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_ptr + PW'(pull_ok);
    end
  end

  // Sample storage is deliberately not reset
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {SampQ, SampI};
    end
  end

  // Fall-through head, forced to zero while empty
  assign head = Empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign OutI = head[W-1:0];
  assign OutQ = head[DW-1:W];

`ifdef IQ_FIFO_ERR_EN
  logic       ovf_evt;
  logic       unf_evt;
  logic       overflow_q;
  logic       underflow_q;
  logic [7:0] drop_cnt_q;

  assign ovf_evt = PushIn && Full && !PullOut;
  assign unf_evt = PullOut && Empty;

  // Sticky error state. A new error wins over a simultaneous clear.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      if (ovf_evt) begin
        overflow_q <= 1'b1;
      end else if (ClrErr) begin
        overflow_q <= 1'b0;
      end

      if (unf_evt) begin
        underflow_q <= 1'b1;
      end else if (ClrErr) begin
        underflow_q <= 1'b0;
      end

      if (ovf_evt) begin
        if (ClrErr) begin
          drop_cnt_q <= 8'd1;
        end else if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end else if (ClrErr) begin
        drop_cnt_q <= 8'd0;
      end
    end
  end

  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
  assign DropCnt   = drop_cnt_q;
`else
  // Error tracking is compiled out, so ClrErr has no effect
  logic unused_clr_err;
  assign unused_clr_err = ClrErr;

  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
  assign DropCnt   = 8'd0;
`endif

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Self-checking bench for iq_sample_fifo (W=24, DEPTH=4).
// A queue-based reference model predicts every output after every clock.
module tb_iq_sample_fifo;

  localparam int unsigned W     = 24;
  localparam int unsigned DEPTH = 4;

  logic          Clk;
  logic          ResetN;
  logic          PushIn;
  logic [W-1:0]  SampI;
  logic [W-1:0]  SampQ;
  logic          PullOut;
  logic [W-1:0]  OutI;
  logic [W-1:0]  OutQ;
  logic          Empty;
  logic          Full;
  logic          AlmostFull;
  logic [2:0]    Count;
  logic          ClrErr;
  logic          Overflow;
  logic          Underflow;
  logic [7:0]    DropCnt;

  iq_sample_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .ResetN(ResetN), .PushIn(PushIn), .SampI(SampI), .SampQ(SampQ),
    .PullOut(PullOut), .OutI(OutI), .OutQ(OutQ), .Empty(Empty), .Full(Full),
    .AlmostFull(AlmostFull), .Count(Count), .ClrErr(ClrErr),
    .Overflow(Overflow), .Underflow(Underflow), .DropCnt(DropCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

`ifdef IQ_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Reference model state
  typedef struct packed { logic [W-1:0] q; logic [W-1:0] i; } samp_t;
  samp_t m_q[$];
  bit    m_ovf;
  bit    m_unf;
  int    m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 0;
    m_unf  = 0;
    m_drop = 0;
  endtask

  // Apply one clock of the FIFO rules to the model
  task automatic model_update(input bit push, input samp_t s, input bit pull, input bit clr);
    bit full_b, empty_b, ovf_e, unf_e;
    full_b  = (m_q.size() == DEPTH);
    empty_b = (m_q.size() == 0);
    ovf_e   = push && full_b && !pull;
    unf_e   = pull && empty_b;
    if (pull && !empty_b) void'(m_q.pop_front());
    if (push && (!full_b || pull)) m_q.push_back(s);
    if (ERR_EN) begin
      if (ovf_e) m_ovf = 1; else if (clr) m_ovf = 0;
      if (unf_e) m_unf = 1; else if (clr) m_unf = 0;
      if (ovf_e) m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      else if (clr) m_drop = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] ei, eq;
    ei = (m_q.size() == 0) ? '0 : m_q[0].i;
    eq = (m_q.size() == 0) ? '0 : m_q[0].q;
    chk({tag, ".count"}, 64'(Count),      64'(m_q.size()));
    chk({tag, ".empty"}, 64'(Empty),      64'(m_q.size() == 0));
    chk({tag, ".full"},  64'(Full),       64'(m_q.size() == DEPTH));
    chk({tag, ".af"},    64'(AlmostFull), 64'(m_q.size() >= DEPTH - 1));
    chk({tag, ".outi"},  64'(OutI),       64'(ei));
    chk({tag, ".outq"},  64'(OutQ),       64'(eq));
    chk({tag, ".ovf"},   64'(Overflow),   64'(m_ovf));
    chk({tag, ".unf"},   64'(Underflow),  64'(m_unf));
    chk({tag, ".drop"},  64'(DropCnt),    64'(m_drop));
  endtask

  // Drive one cycle, clock it, update the model, then check #1 after the edge
  task automatic step(input bit push, input logic [W-1:0] i, input logic [W-1:0] q,
                      input bit pull, input bit clr, input string tag);
    samp_t s;
    PushIn  = push;
    SampI   = i;
    SampQ   = q;
    PullOut = pull;
    ClrErr  = clr;
    s.i = i;
    s.q = q;
    @(posedge Clk);
    model_update(push, s, pull, clr);
    #1;
    check_model(tag);
  endtask

  task automatic push_i(input logic [W-1:0] i, input string tag);
    step(1'b1, i, i + 24'h100000, 1'b0, 1'b0, tag);
  endtask

  task automatic pull_one(input string tag);
    step(1'b0, '0, '0, 1'b1, 1'b0, tag);
  endtask

  typedef struct {
    bit           push;
    bit           pull;
    logic [W-1:0] i;
    int           exp_count;
    bit           exp_empty;
    bit           exp_full;
    bit           exp_af;
    logic [W-1:0] exp_outi;
  } vec_t;

  vec_t tbl[8];

  initial begin
    ResetN  = 1'b0;
    PushIn  = 1'b0;
    PullOut = 1'b0;
    ClrErr  = 1'b0;
    SampI   = '0;
    SampQ   = '0;
    model_reset();

    // Reset state is asserted before any clock edge
    #2;
    chk("reset.count", 64'(Count), 64'd0);
    chk("reset.empty", 64'(Empty), 64'd1);
    chk("reset.full",  64'(Full),  64'd0);
    chk("reset.af",    64'(AlmostFull), 64'd0);
    chk("reset.outi",  64'(OutI),  64'd0);
    chk("reset.outq",  64'(OutQ),  64'd0);
    chk("reset.ovf",   64'(Overflow), 64'd0);
    chk("reset.drop",  64'(DropCnt),  64'd0);
    @(negedge Clk);
    @(negedge Clk);
    ResetN = 1'b1;

    // Fill with 1..4, then drain four times
    tbl[0] = '{1'b1, 1'b0, 24'h000001, 1, 1'b0, 1'b0, 1'b0, 24'h000001};
    tbl[1] = '{1'b1, 1'b0, 24'h000002, 2, 1'b0, 1'b0, 1'b0, 24'h000001};
    tbl[2] = '{1'b1, 1'b0, 24'h000003, 3, 1'b0, 1'b0, 1'b1, 24'h000001};
    tbl[3] = '{1'b1, 1'b0, 24'h000004, 4, 1'b0, 1'b1, 1'b1, 24'h000001};
    tbl[4] = '{1'b0, 1'b1, 24'h000000, 3, 1'b0, 1'b0, 1'b1, 24'h000002};
    tbl[5] = '{1'b0, 1'b1, 24'h000000, 2, 1'b0, 1'b0, 1'b0, 24'h000003};
    tbl[6] = '{1'b0, 1'b1, 24'h000000, 1, 1'b0, 1'b0, 1'b0, 24'h000004};
    tbl[7] = '{1'b0, 1'b1, 24'h000000, 0, 1'b1, 1'b0, 1'b0, 24'h000000};
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].push, tbl[k].i, tbl[k].i + 24'h100000, tbl[k].pull, 1'b0, "tbl");
      chk($sformatf("tbl%0d.count", k), 64'(Count), 64'(tbl[k].exp_count));
      chk($sformatf("tbl%0d.empty", k), 64'(Empty), 64'(tbl[k].exp_empty));
      chk($sformatf("tbl%0d.full", k),  64'(Full),  64'(tbl[k].exp_full));
      chk($sformatf("tbl%0d.af", k),    64'(AlmostFull), 64'(tbl[k].exp_af));
      chk($sformatf("tbl%0d.outi", k),  64'(OutI),  64'(tbl[k].exp_outi));
    end

    // Full with push and no pull: the push is dropped
    for (int k = 1; k <= 4; k++) push_i(W'(k), "ovf.fill");
    push_i(24'h000005, "ovf.push");
    chk("ovf.count", 64'(Count), 64'd4);
    chk("ovf.flag",  64'(Overflow), 64'(ERR_EN));
    chk("ovf.drop",  64'(DropCnt),  64'(ERR_EN));
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf.drain%0d", k), 64'(OutI), 64'(k));
      pull_one("ovf.drain");
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, "clr");
    chk("clr.ovf", 64'(Overflow), 64'd0);

    // Full with simultaneous push and pull: head consumed, no overflow
    for (int k = 1; k <= 4; k++) push_i(W'(k), "pp.fill");
    step(1'b1, 24'h0000AA, 24'h1000AA, 1'b1, 1'b0, "pp.both");
    chk("pp.count", 64'(Count), 64'd4);
    chk("pp.ovf",   64'(Overflow), 64'd0);
    chk("pp.head",  64'(OutI), 64'd2);
    for (int k = 0; k < 3; k++) pull_one("pp.drain");
    chk("pp.last", 64'(OutI), 64'h0000AA);
    pull_one("pp.drain");
    chk("pp.empty", 64'(Empty), 64'd1);

    // Empty with simultaneous push and pull: pull ignored, push lands
    step(1'b1, 24'h000033, 24'h100033, 1'b1, 1'b0, "unf.both");
    chk("unf.flag",  64'(Underflow), 64'(ERR_EN));
    chk("unf.count", 64'(Count), 64'd1);
    chk("unf.outi",  64'(OutI), 64'h000033);
    pull_one("unf.drain");
    step(1'b0, '0, '0, 1'b0, 1'b1, "clr2");

    // Three full fill/drain cycles across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) push_i(W'(24'h000100 + 16 * r + k), "wrap.fill");
      chk("wrap.full", 64'(Full), 64'd1);
      for (int k = 0; k < 4; k++) begin
        chk("wrap.order", 64'(OutI), 64'(24'h000100 + 16 * r + k));
        pull_one("wrap.drain");
      end
      chk("wrap.empty", 64'(Empty), 64'd1);
    end

    // DropCnt saturation, then a clear colliding with a new overflow
    for (int k = 1; k <= 4; k++) push_i(W'(k), "sat.fill");
    for (int k = 0; k < 300; k++) push_i(24'h0000EE, "sat.drop");
    chk("sat.drop", 64'(DropCnt), ERR_EN ? 64'd255 : 64'd0);
    step(1'b1, 24'h0000EF, 24'h1000EF, 1'b0, 1'b1, "clrovf");
    chk("clrovf.flag", 64'(Overflow), 64'(ERR_EN));
    chk("clrovf.drop", 64'(DropCnt),  64'(ERR_EN));

    // Asynchronous reset mid-cycle with two entries held
    pull_one("ar.pull");
    pull_one("ar.pull");
    chk("ar.count_pre", 64'(Count), 64'd2);
    @(negedge Clk);
    ResetN = 1'b0;
    #1;
    model_reset();
    chk("ar.count", 64'(Count), 64'd0);
    chk("ar.empty", 64'(Empty), 64'd1);
    chk("ar.outi",  64'(OutI),  64'd0);
    chk("ar.ovf",   64'(Overflow), 64'd0);
    chk("ar.drop",  64'(DropCnt),  64'd0);
    @(negedge Clk);
    ResetN = 1'b1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 55), W'($urandom), W'($urandom),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 4), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
